ula_seq: RTL and testbench

ULA_SEQ -- requirements
Module: ula_seq

---
 rtl/ula_pkg.sv | 23 ++
 rtl/ula_iter.sv | 113 +++++++++++
 rtl/ula_seq.sv | 121 ++++++++++++
 tb/tb_ula_seq.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared opcode/state encodings and sizing helper for the ula_seq ALU.
package ula_pkg;

    typedef enum logic [2:0] {
        OP_ZERO = 3'b000,
        OP_SOMA = 3'b001,
        OP_SUB  = 3'b010,
        OP_MULT = 3'b011,
        OP_DIV  = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        CALC   = 2'd1,
        FIM    = 2'd2
    } state_e;

    // Counter width able to hold iteration indices 0..width-1.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/ula_iter.sv
// Iterative datapath for ula_seq: shift-add multiplier and, with ULA_DIV_EN defined,
// a restoring divider sharing the counter and operand shift register.
module ula_iter
    import ula_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 run,
`ifdef ULA_DIV_EN
    input  logic                 div_mode,
`endif
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 last,
    output logic [2*WIDTH-1:0]   res_nxt
);
    localparam int RW    = 2 * WIDTH;
    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RW-1:0]    acc_q, acc_d;
    logic [RW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] shf_q, shf_d;
`ifdef ULA_DIV_EN
    logic             div_q, div_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH:0]   trial;
`endif

    always_comb begin
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        shf_d   = shf_q;
`ifdef ULA_DIV_EN
        div_d   = div_q;
        rem_d   = rem_q;
        dvsr_d  = dvsr_q;
        trial   = '0;
`endif
        if (start) begin
            cnt_d   = '0;
            acc_d   = '0;
            mcand_d = RW'(op_a);
            shf_d   = op_b;
`ifdef ULA_DIV_EN
            div_d   = div_mode;
            rem_d   = '0;
            dvsr_d  = op_b;
            if (div_mode) shf_d = op_a;
`endif
        end else if (run) begin
            cnt_d = cnt_q + 1'b1;
`ifdef ULA_DIV_EN
            if (div_q) begin
                // Shift the next dividend bit into the remainder and keep the trial only if non-negative.
                trial = {rem_q, shf_q[WIDTH-1]} - {1'b0, dvsr_q};
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    shf_d = {shf_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = {rem_q[WIDTH-2:0], shf_q[WIDTH-1]};
                    shf_d = {shf_q[WIDTH-2:0], 1'b0};
                end
            end else
`endif
            begin
                if (shf_q[0]) acc_d = acc_q + mcand_q;
                mcand_d = mcand_q << 1;
                shf_d   = shf_q >> 1;
            end
        end
    end

    // The last step's outcome is forwarded combinationally so the FSM can register it on the same edge.
    always_comb begin
        last    = (cnt_q == CNT_LAST);
        res_nxt = acc_d;
`ifdef ULA_DIV_EN
        if (div_q) res_nxt = {rem_d, shf_d};
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            shf_q   <= '0;
`ifdef ULA_DIV_EN
            div_q   <= 1'b0;
            rem_q   <= '0;
            dvsr_q  <= '0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            shf_q   <= shf_d;
`ifdef ULA_DIV_EN
            div_q   <= div_d;
            rem_q   <= rem_d;
            dvsr_q  <= dvsr_d;
`endif
        end
    end

endmodule

// File: rtl/ula_seq.sv
// Sequential ALU (zero/add/sub/mult, plus div when ULA_DIV_EN is defined) with a
// three-state FSM driving the ula_iter datapath; all outputs are registered.
module ula_seq
    import ula_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     num1,
    input  logic [WIDTH-1:0]     num2,
    input  logic [2:0]           operacao,
    input  logic                 inicio,
    output logic [2*WIDTH-1:0]   resultado,
    output logic                 pronto,
    output logic                 ocupado,
    output logic                 erro
);
    localparam int RW = 2 * WIDTH;

    state_e        state_q, state_d;
    logic [RW-1:0] resultado_q, resultado_d;
    logic          pronto_q, pronto_d;
    logic          ocupado_q, ocupado_d;
    logic          erro_q, erro_d;
    logic          accept;
    logic          iter_start;
    logic          iter_last;
    logic [RW-1:0] iter_res;
`ifdef ULA_DIV_EN
    logic          iter_div;
`endif

    ula_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .reset    (reset),
        .start    (iter_start),
        .run      (state_q == CALC),
`ifdef ULA_DIV_EN
        .div_mode (iter_div),
`endif
        .op_a     (num1),
        .op_b     (num2),
        .last     (iter_last),
        .res_nxt  (iter_res)
    );

    always_comb begin
        state_d     = state_q;
        resultado_d = resultado_q;
        erro_d      = erro_q;
        iter_start  = 1'b0;
`ifdef ULA_DIV_EN
        iter_div    = 1'b0;
`endif
        accept = inicio && (state_q != CALC);
        if (state_q == CALC) begin
            if (iter_last) begin
                state_d     = FIM;
                resultado_d = iter_res;
                erro_d      = 1'b0;
            end
        end else if (accept) begin
            state_d = FIM;
            erro_d  = 1'b0;
            case (op_e'(operacao))
                OP_ZERO: resultado_d = '0;
                OP_SOMA: resultado_d = RW'(num1) + RW'(num2);
                OP_SUB:  resultado_d = RW'(num1) - RW'(num2);
                OP_MULT: begin
                    state_d    = CALC;
                    iter_start = 1'b1;
                    erro_d     = erro_q;
                end
`ifdef ULA_DIV_EN
                OP_DIV: begin
                    if (num2 == '0) begin
                        resultado_d = {num1, {WIDTH{1'b1}}};
                        erro_d      = 1'b1;
                    end else begin
                        state_d    = CALC;
                        iter_start = 1'b1;
                        iter_div   = 1'b1;
                        erro_d     = erro_q;
                    end
                end
`endif
                default: begin
                    resultado_d = '0;
                    erro_d      = 1'b1;
                end
            endcase
        end else begin
            state_d = OCIOSO;
        end
        pronto_d  = (state_d == FIM);
        ocupado_d = (state_d == CALC);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= OCIOSO;
            resultado_q <= '0;
            pronto_q    <= 1'b0;
            ocupado_q   <= 1'b0;
            erro_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            resultado_q <= resultado_d;
            pronto_q    <= pronto_d;
            ocupado_q   <= ocupado_d;
            erro_q      <= erro_d;
        end
    end

    assign resultado = resultado_q;
    assign pronto    = pronto_q;
    assign ocupado   = ocupado_q;
    assign erro      = erro_q;

endmodule

// File: tb/tb_ula_seq.sv
// Randomized self-checking bench for ula_seq (WIDTH=4) against a transaction-level model.
module tb_ula_seq;
    localparam int W  = 4;
    localparam int RW = 2 * W;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  num1, num2;
    logic [2:0]    operacao;
    logic          inicio;
    logic [RW-1:0] resultado;
    logic          pronto, ocupado, erro;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [RW-1:0] held_res;
    logic          held_err;

    ula_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .num1      (num1),
        .num2      (num2),
        .operacao  (operacao),
        .inicio    (inicio),
        .resultado (resultado),
        .pronto    (pronto),
        .ocupado   (ocupado),
        .erro      (erro)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected result, error flag and latency (cycles from accept edge to pronto) of one operation.
    function automatic void model(input logic [2:0] op, input int a, input int b,
                                  output logic [RW-1:0] res, output logic err, output int lat);
        res = '0;
        err = 1'b0;
        lat = 1;
        case (op)
            3'd0: res = '0;
            3'd1: res = RW'(a + b);
            3'd2: res = RW'(a - b + (1 << RW));
            3'd3: begin
                res = RW'(a * b);
                lat = W + 1;
            end
`ifdef ULA_DIV_EN
            3'd4: begin
                if (b == 0) begin
                    res = RW'((a << W) + (1 << W) - 1);
                    err = 1'b1;
                end else begin
                    res = RW'(((a % b) << W) + (a / b));
                    lat = W + 1;
                end
            end
`endif
            default: err = 1'b1;
        endcase
    endfunction

    // Starts one op, checks the busy window, and returns in the pronto cycle.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit disturb, input string tag);
        logic [RW-1:0] er;
        logic          ee;
        int            lat;
        model(op, int'(a), int'(b), er, ee, lat);
        num1 = a; num2 = b; operacao = op; inicio = 1'b1;
        tick;
        inicio = 1'b0;
        num1 = W'($urandom); num2 = W'($urandom); operacao = 3'($urandom);
        for (int k = 1; k < lat; k++) begin
            chk({tag, " busy pronto"}, 32'(pronto), 32'd0);
            chk({tag, " busy ocupado"}, 32'(ocupado), 32'd1);
            chk({tag, " busy hold resultado"}, 32'(resultado), 32'(held_res));
            chk({tag, " busy hold erro"}, 32'(erro), 32'(held_err));
            inicio = disturb ? 1'($urandom) : 1'b0;
            num1 = W'($urandom); num2 = W'($urandom); operacao = 3'($urandom);
            tick;
            inicio = 1'b0;
        end
        chk({tag, " pronto"}, 32'(pronto), 32'd1);
        chk({tag, " ocupado"}, 32'(ocupado), 32'd0);
        chk({tag, " resultado"}, 32'(resultado), 32'(er));
        chk({tag, " erro"}, 32'(erro), 32'(ee));
        held_res = er;
        held_err = ee;
    endtask

    task automatic idle(input string tag);
        inicio = 1'b0;
        tick;
        chk({tag, " idle pronto"}, 32'(pronto), 32'd0);
        chk({tag, " idle ocupado"}, 32'(ocupado), 32'd0);
        chk({tag, " idle resultado"}, 32'(resultado), 32'(held_res));
        chk({tag, " idle erro"}, 32'(erro), 32'(held_err));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " resultado"}, 32'(resultado), 32'd0);
        chk({tag, " pronto"}, 32'(pronto), 32'd0);
        chk({tag, " ocupado"}, 32'(ocupado), 32'd0);
        chk({tag, " erro"}, 32'(erro), 32'd0);
    endtask

    initial begin
        logic [2:0]   op;
        logic [W-1:0] a, b;
        reset = 1'b1; inicio = 1'b0; num1 = '0; num2 = '0; operacao = '0;
        held_res = '0; held_err = 1'b0;

        // Reset with a start request present: request must be dropped.
        num1 = 4'd9; num2 = 4'd7; operacao = 3'd1; inicio = 1'b1;
        tick;
        tick;
        check_zero("reset");
        reset = 1'b0; inicio = 1'b0;
        tick;
        chk("reset inicio ignored", 32'(pronto), 32'd0);

        issue(3'd1, 4'd9, 4'd7, 1'b0, "add 9+7");      idle("add");
        issue(3'd2, 4'd3, 4'd5, 1'b0, "sub 3-5");      idle("sub");
        issue(3'd3, 4'd15, 4'd15, 1'b0, "mult 15*15"); idle("mult");
        issue(3'd0, 4'd6, 4'd2, 1'b0, "zero");         idle("zero");
        issue(3'd5, 4'd1, 4'd1, 1'b0, "rsv 101");      idle("rsv");
        issue(3'd4, 4'd13, 4'd4, 1'b0, "div 13/4");    idle("div");
        issue(3'd4, 4'd13, 4'd0, 1'b0, "div 13/0");    idle("div0");
        issue(3'd3, 4'd11, 4'd13, 1'b1, "mult disturbed"); idle("mult disturbed");

        // Back-to-back: a new op accepted in the pronto cycle of a mult.
        issue(3'd3, 4'd7, 4'd9, 1'b0, "b2b mult");
        issue(3'd3, 4'd12, 4'd5, 1'b0, "b2b mult2");
        issue(3'd1, 4'd15, 4'd15, 1'b0, "b2b add");
        idle("b2b");

        // Reset during the second CALC cycle aborts the mult with no pronto.
        num1 = 4'd15; num2 = 4'd15; operacao = 3'd3; inicio = 1'b1;
        tick;
        inicio = 1'b0;
        tick;
        chk("abort pre ocupado", 32'(ocupado), 32'd1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check_zero("abort");
        held_res = '0; held_err = 1'b0;
        for (int k = 0; k < W + 2; k++) begin
            tick;
            chk("abort no pronto", 32'(pronto), 32'd0);
        end
        issue(3'd1, 4'd9, 4'd7, 1'b0, "post-reset add");
        idle("post-reset");

        for (int i = 0; i < 200; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = W'($urandom);
            b  = W'($urandom);
            if (op == 3'd4 && $urandom_range(0, 3) == 0) b = '0;
            issue(op, a, b, 1'($urandom), "rand");
            if ($urandom_range(0, 2) != 0) idle("rand");
        end
        idle("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
